// File: rtl/tl_sensor_cond_pkg.sv
// Shared defaults and encodings for the traffic-light controller slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tl_sensor_cond_pkg;

    localparam int DEF_PRESCALE   = 4;
    localparam int DEF_DEB_CNT    = 3;
    localparam int DEF_HOLD_TICKS = 5;

    // Controller state encodings, kept here so the next-state logic and this stage agree.
    typedef enum logic [1:0] {
        S0_A_GREEN  = 2'b00,
        S1_A_YELLOW = 2'b01,
        S2_B_GREEN  = 2'b10,
        S3_B_YELLOW = 2'b11
    } tl_state_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tl_sensor_cond_if.sv
// Sensor-side signal bundle: raw street sensors in, conditioned levels and tick out.
// Latency: n/a (wires only).
// Backpressure: none; levels and a free-running pulse.
interface tl_sensor_cond_if;

    logic sa_raw;
    logic sb_raw;
    logic ta;
    logic tb;
    logic tick;

    modport master (
        output sa_raw,
        output sb_raw,
        input  ta,
        input  tb,
        input  tick
    );

    modport slave (
        input  sa_raw,
        input  sb_raw,
        output ta,
        output tb,
        output tick
    );

endinterface

// File: rtl/tl_debounce.sv
// One sensor channel: 2-flop synchronizer plus tick-sampled debounce (optional hold via TL_SENSOR_STRETCH_EN).
// Latency: 2 sync clocks + wait for tick + (DEB_CNT-1) ticks + 1 clock.
// Backpressure: none; out only moves in the cycle after a tick.
module tl_debounce
    import tl_sensor_cond_pkg::*;
#(
    parameter int DEB_CNT    = DEF_DEB_CNT
`ifdef TL_SENSOR_STRETCH_EN
   ,parameter int HOLD_TICKS = DEF_HOLD_TICKS
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic out
);

    localparam int               DCW       = cnt_width(DEB_CNT);
    localparam logic [DCW-1:0]   DCNT_LAST = DCW'(DEB_CNT - 1);

    logic           s1;
    logic           s2;
    logic [DCW-1:0] dcnt;
    logic           blocked;
    logic           change;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef TL_SENSOR_STRETCH_EN
    localparam int             HW      = cnt_width(HOLD_TICKS + 1);
    localparam logic [HW-1:0]  HOLD_LD = HW'(HOLD_TICKS);

    logic [HW-1:0] hold;

    // A raised output may not start its falling qualification until hold drains.
    assign blocked = out && (hold != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (tick) begin
            if (change && s2)
                hold <= HOLD_LD;
            else if (hold != '0)
                hold <= hold - 1'b1;
        end
    end
`else
    assign blocked = 1'b0;
`endif

    assign change = (s2 != out) && !blocked && (dcnt == DCNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt <= '0;
            out  <= 1'b0;
        end else if (tick) begin
            if ((s2 == out) || blocked) begin
                dcnt <= '0;
            end else if (change) begin
                out  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning: prescaled sample tick plus two debounced street sensors (TL_SENSOR_STRETCH_EN adds min-high hold).
// Latency: raw edge to ta/tb edge = 2 + to-next-tick + (DEB_CNT-1)*PRESCALE + 1 clocks.
// Backpressure: none; tick is free-running and ta/tb are stable through every tick cycle.
module tl_sensor_cond
    import tl_sensor_cond_pkg::*;
#(
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int DEB_CNT    = DEF_DEB_CNT
`ifdef TL_SENSOR_STRETCH_EN
   ,parameter int HOLD_TICKS = DEF_HOLD_TICKS
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    tl_sensor_cond_if.slave     sif
);

    localparam int             PW         = cnt_width(PRESCALE);
    localparam logic [PW-1:0]  PCNT_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pcnt <= '0;
        else if (pcnt == PCNT_LAST)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    // Decoded from the register so tick is glitch-free for the downstream state enable.
    assign tick     = (pcnt == PCNT_LAST);
    assign sif.tick = tick;

    tl_debounce #(
        .DEB_CNT    (DEB_CNT)
`ifdef TL_SENSOR_STRETCH_EN
       ,.HOLD_TICKS (HOLD_TICKS)
`endif
    ) u_deb_a (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .raw     (sif.sa_raw),
        .out     (sif.ta)
    );

    tl_debounce #(
        .DEB_CNT    (DEB_CNT)
`ifdef TL_SENSOR_STRETCH_EN
       ,.HOLD_TICKS (HOLD_TICKS)
`endif
    ) u_deb_b (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .raw     (sif.sb_raw),
        .out     (sif.tb)
    );

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Directed bench for tl_sensor_cond at PRESCALE=4, DEB_CNT=3, HOLD_TICKS=5.
// Cycle k is the period ending at the k-th rising edge after reset release.
module tb_tl_sensor_cond;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    tl_sensor_cond_if sif ();

    tl_sensor_cond dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; outputs are read 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic a, input logic b);
        reset_n    = 1'b0;
        sif.sa_raw = a;
        sif.sb_raw = b;
        repeat (3) step();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        sif.sa_raw = 1'b1;
        sif.sb_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if ({sif.ta, sif.tb, sif.tick} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d {ta,tb,tick}=%b expected 000", i, {sif.ta, sif.tb, sif.tick});
            end
        end
        sif.sa_raw = 1'b0;
        sif.sb_raw = 1'b0;
        reset_n    = 1'b1;
        cyc        = 0;
        for (int c = 0; c <= 12; c++) begin
            logic exp_tick;
            exp_tick = ((c % 4) == 3);
            n_tests++;
            if (sif.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL reset_tick cycle=%0d tick=%b expected %b", c, sif.tick, exp_tick);
            end
            n_tests++;
            if (sif.ta !== 1'b0 || sif.tb !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle=%0d ta=%b tb=%b expected 0 0", c, sif.ta, sif.tb);
            end
            step();
        end
    endtask

    task automatic test_rise();
        do_reset(1'b0, 1'b0);
        for (int c = 0; c <= 20; c++) begin
            logic exp_ta;
            exp_ta = (c >= 12);
            n_tests++;
            if (sif.ta !== exp_ta || sif.tb !== 1'b0) begin
                n_fail++;
                $display("FAIL rise cycle=%0d ta=%b tb=%b expected %b 0", c, sif.ta, sif.tb, exp_ta);
            end
            sif.sa_raw = 1'b1;
            step();
        end
    endtask

    task automatic test_b_only();
        do_reset(1'b0, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            logic exp_tb;
            exp_tb = (c >= 12);
            n_tests++;
            if (sif.tb !== exp_tb || sif.ta !== 1'b0) begin
                n_fail++;
                $display("FAIL b_only cycle=%0d ta=%b tb=%b expected 0 %b", c, sif.ta, sif.tb, exp_tb);
            end
            sif.sb_raw = 1'b1;
            step();
        end
    endtask

    // Two-tick pulse is rejected; a later steady high needs a full fresh qualification.
    task automatic test_glitch();
        do_reset(1'b0, 1'b0);
        for (int c = 0; c <= 30; c++) begin
            logic exp_ta;
            exp_ta = (c >= 24);
            n_tests++;
            if (sif.ta !== exp_ta) begin
                n_fail++;
                $display("FAIL glitch cycle=%0d ta=%b expected %b", c, sif.ta, exp_ta);
            end
            sif.sa_raw = (c <= 7) || (c >= 12);
            step();
        end
    endtask

    task automatic test_simul();
        do_reset(1'b0, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            logic exp_t;
            exp_t = (c >= 12);
            n_tests++;
            if (sif.ta !== exp_t || sif.tb !== exp_t) begin
                n_fail++;
                $display("FAIL simul cycle=%0d ta=%b tb=%b expected %b %b", c, sif.ta, sif.tb, exp_t, exp_t);
            end
            sif.sa_raw = 1'b1;
            sif.sb_raw = 1'b1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            sif.sa_raw = 1'b1;
            step();
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({sif.ta, sif.tick} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_assert {ta,tick}=%b expected 00", {sif.ta, sif.tick});
        end
        step();
        reset_n = 1'b1;
        cyc     = 0;
        for (int c = 0; c <= 14; c++) begin
            logic exp_ta;
            exp_ta = (c >= 12);
            n_tests++;
            if (sif.ta !== exp_ta) begin
                n_fail++;
                $display("FAIL reset_mid cycle=%0d ta=%b expected %b", c, sif.ta, exp_ta);
            end
            step();
        end
    endtask

    task automatic test_stretch();
        int fall;
`ifdef TL_SENSOR_STRETCH_EN
        fall = 44;
`else
        fall = 24;
`endif
        do_reset(1'b0, 1'b0);
        for (int c = 0; c <= 50; c++) begin
            logic exp_ta;
            exp_ta = (c >= 12) && (c < fall);
            n_tests++;
            if (sif.ta !== exp_ta) begin
                n_fail++;
                $display("FAIL stretch cycle=%0d ta=%b expected %b", c, sif.ta, exp_ta);
            end
            sif.sa_raw = (c < 13);
            step();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        sif.sa_raw = 1'b0;
        sif.sb_raw = 1'b0;
        test_reset();
        test_rise();
        test_b_only();
        test_glitch();
        test_simul();
        test_reset_mid();
        test_stretch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
